// File: rtl/axis_rr_stream_arbiter.sv
// Round-robin packet arbiter merging N beat streams into one AXI4-Stream
// master with a registered output stage and per-channel overflow flags.
module axis_rr_stream_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 128,
  parameter int DEST_WIDTH = 8,
  parameter int MAX_BEATS  = 256,
  localparam int IDX_W     = $clog2(NUM_CH),
  localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic [NUM_CH-1:0]            ch_enable,
  input  logic [NUM_CH-1:0]            ch_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] ch_data,
  input  logic [NUM_CH-1:0]            ch_last,
  output logic [NUM_CH-1:0]            ch_ready,
  output logic [DATA_WIDTH-1:0]        stream_tdata,
  output logic [DEST_WIDTH-1:0]        stream_tdest,
  output logic [DATA_WIDTH/8-1:0]      stream_tkeep,
  output logic                         stream_tlast,
  output logic                         stream_tvalid,
  input  logic                         stream_tready,
  output logic [IDX_W-1:0]             grant_idx,
  output logic                         busy,
  output logic [NUM_CH-1:0]            overflow_err,
  input  logic                         err_clear
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  localparam logic [IDX_W:0]   NCH     = (IDX_W+1)'(NUM_CH);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

  state_e state_q, state_d;

  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] win_idx, sel;
  logic [IDX_W-1:0] pos;
  logic [IDX_W:0]   sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] err_q, err_d;
  logic [NUM_CH-1:0] req, ready;
  logic win_found;
  logic out_free;
  logic accept;
  logic forced;
  logic beat_last;
  logic [DATA_WIDTH-1:0] sel_data;

  logic                  tvalid_q;
  logic                  tlast_q;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic [DEST_WIDTH-1:0] tdest_q;

  assign req      = ch_valid & ch_enable;
  assign out_free = !tvalid_q || stream_tready;

  // Scan starts just past the last grant and wraps at NUM_CH.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    sum       = '0;
    pos       = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      sum = {1'b0, last_q} + (IDX_W+1)'(k);
      if (sum >= NCH) sum = sum - NCH;
      pos = sum[IDX_W-1:0];
      if (!win_found && req[pos]) begin
        win_found = 1'b1;
        win_idx   = pos;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    ready     = '0;
    accept    = 1'b0;
    forced    = 1'b0;
    beat_last = 1'b0;
    sel       = grant_q;
    err_d     = err_clear ? '0 : err_q;
    if (resetn) begin
      unique case (state_q)
        IDLE: begin
          if (win_found && out_free) begin
            sel     = win_idx;
            accept  = 1'b1;
            last_d  = win_idx;
            grant_d = win_idx;
            cnt_d   = CNT_W'(1);
            forced  = !ch_last[win_idx] && (MAX_BEATS == 1);
            if (!ch_last[win_idx] && (MAX_BEATS != 1))
              state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (ch_valid[grant_q] && out_free) begin
            accept = 1'b1;
            cnt_d  = cnt_q + CNT_W'(1);
            forced = !ch_last[grant_q] && (cnt_d == MAX_CNT);
            if (ch_last[grant_q] || forced)
              state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (accept) begin
      ready[sel] = 1'b1;
      beat_last  = ch_last[sel] || forced;
    end
    // A new truncation outranks a same-cycle clear.
    if (forced) err_d[sel] = 1'b1;
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (sel == IDX_W'(i))
        sel_data = ch_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_CH - 1);
      grant_q <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      tdest_q  <= '0;
    end else if (accept) begin
      tvalid_q <= 1'b1;
      tlast_q  <= beat_last;
      tdata_q  <= sel_data;
      tdest_q  <= DEST_WIDTH'(sel);
    end else if (stream_tready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign ch_ready      = ready;
  assign stream_tdata  = tdata_q;
  assign stream_tdest  = tdest_q;
  assign stream_tkeep  = '1;
  assign stream_tlast  = tlast_q;
  assign stream_tvalid = tvalid_q;
  assign grant_idx     = grant_q;
  assign busy          = (state_q == LOCKED);
  assign overflow_err  = err_q;

endmodule

// File: tb/tb_axis_rr_stream_arbiter.sv
// Directed bench: 4-channel arbiter (MAX_BEATS=4) plus a 3-channel
// instance for the enable-mask scenario.
module tb_axis_rr_stream_arbiter;

  localparam int DW = 32;
  localparam int BW = 16;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  logic [3:0]      a_en, a_valid, a_last, a_ready, a_err;
  logic [4*DW-1:0] a_data;
  logic [DW-1:0]   a_tdata;
  logic [7:0]      a_tdest;
  logic [DW/8-1:0] a_tkeep;
  logic            a_tlast, a_tvalid, a_tready, a_busy, a_clr;
  logic [1:0]      a_grant;

  logic [2:0]      b_en, b_valid, b_last, b_ready, b_err;
  logic [3*BW-1:0] b_data;
  logic [BW-1:0]   b_tdata;
  logic [7:0]      b_tdest;
  logic [BW/8-1:0] b_tkeep;
  logic            b_tlast, b_tvalid, b_tready, b_busy, b_clr;
  logic [1:0]      b_grant;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  axis_rr_stream_arbiter #(
    .NUM_CH(4), .DATA_WIDTH(DW), .DEST_WIDTH(8), .MAX_BEATS(4)
  ) u_a (
    .clk(clk), .resetn(resetn),
    .ch_enable(a_en), .ch_valid(a_valid), .ch_data(a_data),
    .ch_last(a_last), .ch_ready(a_ready),
    .stream_tdata(a_tdata), .stream_tdest(a_tdest),
    .stream_tkeep(a_tkeep), .stream_tlast(a_tlast),
    .stream_tvalid(a_tvalid), .stream_tready(a_tready),
    .grant_idx(a_grant), .busy(a_busy),
    .overflow_err(a_err), .err_clear(a_clr)
  );

  axis_rr_stream_arbiter #(
    .NUM_CH(3), .DATA_WIDTH(BW), .DEST_WIDTH(8), .MAX_BEATS(4)
  ) u_b (
    .clk(clk), .resetn(resetn),
    .ch_enable(b_en), .ch_valid(b_valid), .ch_data(b_data),
    .ch_last(b_last), .ch_ready(b_ready),
    .stream_tdata(b_tdata), .stream_tdest(b_tdest),
    .stream_tkeep(b_tkeep), .stream_tlast(b_tlast),
    .stream_tvalid(b_tvalid), .stream_tready(b_tready),
    .grant_idx(b_grant), .busy(b_busy),
    .overflow_err(b_err), .err_clear(b_clr)
  );

  task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] dv(int c, int b);
    return DW'(32'hC0DE0000 | (c << 8) | b);
  endfunction

  task automatic set_data(int c, logic [DW-1:0] d);
    a_data[c*DW +: DW] = d;
  endtask

  initial begin
    a_en = '0; a_valid = '0; a_last = '0; a_data = '0;
    a_tready = 1'b1; a_clr = 1'b0;
    b_en = '0; b_valid = '0; b_last = '0;
    b_data = {16'h2222, 16'h1111, 16'h0000};
    b_tready = 1'b1; b_clr = 1'b0;

    // Reset state
    #1;
    check_eq("rst_tvalid", a_tvalid, 0);
    check_eq("rst_tdata", a_tdata, 0);
    check_eq("rst_grant", a_grant, 0);
    check_eq("rst_busy", a_busy, 0);
    check_eq("rst_err", a_err, 0);
    @(negedge clk);
    @(negedge clk);

    // Single-beat packets from every channel rotate 0,1,2,3,0,1
    for (int c = 0; c < 4; c++) set_data(c, dv(c, 0));
    resetn = 1'b1;
    a_en = 4'hF; a_valid = 4'hF; a_last = 4'hF;
    #1 check_eq("t1_ready0", a_ready, 4'b0001);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("t1_tvalid", a_tvalid, 1);
      check_eq("t1_tdest", a_tdest, k % 4);
      check_eq("t1_tdata", a_tdata, dv(k % 4, 0));
    end
    check_eq("t1_tkeep", a_tkeep, 4'hF);
    a_valid = '0;
    @(negedge clk);
    check_eq("t1_idle", a_tvalid, 0);

    // ch1 three-beat packet, then ch2 and ch0
    a_valid = 4'b0010; a_last = 4'b0000;
    set_data(1, dv(1, 1));
    #1 check_eq("t2_ready_b1", a_ready, 4'b0010);
    @(negedge clk);
    a_valid = 4'b0111; a_last = 4'b0101;
    set_data(1, dv(1, 2));
    check_eq("t2_b1_dest", a_tdest, 1);
    check_eq("t2_b1_last", a_tlast, 0);
    check_eq("t2_b1_data", a_tdata, dv(1, 1));
    check_eq("t2_b1_busy", a_busy, 1);
    #1 check_eq("t2_ready_b2", a_ready, 4'b0010);
    @(negedge clk);
    a_last = 4'b0111;
    set_data(1, dv(1, 3));
    check_eq("t2_b2_dest", a_tdest, 1);
    check_eq("t2_b2_last", a_tlast, 0);
    check_eq("t2_b2_data", a_tdata, dv(1, 2));
    check_eq("t2_b2_busy", a_busy, 1);
    #1 check_eq("t2_ready_b3", a_ready, 4'b0010);
    @(negedge clk);
    a_valid = 4'b0101;
    check_eq("t2_b3_dest", a_tdest, 1);
    check_eq("t2_b3_last", a_tlast, 1);
    check_eq("t2_b3_data", a_tdata, dv(1, 3));
    check_eq("t2_b3_busy", a_busy, 0);
    #1 check_eq("t2_ready_ch2", a_ready, 4'b0100);
    @(negedge clk);
    check_eq("t2_ch2_dest", a_tdest, 2);
    #1 check_eq("t2_ready_ch0", a_ready, 4'b0001);
    @(negedge clk);
    check_eq("t2_ch0_dest", a_tdest, 0);
    a_valid = '0;
    @(negedge clk);
    check_eq("t2_idle", a_tvalid, 0);

    // Back-pressure holds the output beat for five cycles
    a_valid = 4'b0100; a_last = 4'b0100;
    set_data(2, dv(2, 7));
    @(negedge clk);
    check_eq("t3_hold_dest", a_tdest, 2);
    a_tready = 1'b0;
    a_valid = 4'b1000; a_last = 4'b1000;
    set_data(3, dv(3, 1));
    #1 check_eq("t3_ready_held", a_ready, 4'b0000);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq("t3_tvalid", a_tvalid, 1);
      check_eq("t3_tdest", a_tdest, 2);
      check_eq("t3_tdata", a_tdata, dv(2, 7));
      check_eq("t3_tlast", a_tlast, 1);
      #1 check_eq("t3_ready", a_ready, 4'b0000);
    end
    a_tready = 1'b1;
    #1 check_eq("t3_ready_resume", a_ready, 4'b1000);
    @(negedge clk);
    check_eq("t3_next_dest", a_tdest, 3);
    check_eq("t3_next_data", a_tdata, dv(3, 1));
    a_valid = '0;
    @(negedge clk);
    check_eq("t3_no_dup", a_tvalid, 0);

    // ch3 six-beat packet truncated at beat 4
    a_valid = 4'b1000; a_last = 4'b0000;
    for (int k = 0; k < 6; k++) begin
      if (k >= 1) begin
        check_eq("t4_dest", a_tdest, 3);
        check_eq("t4_data", a_tdata, dv(3, k));
        check_eq("t4_last", a_tlast, (k == 4) ? 1 : 0);
        check_eq("t4_busy", a_busy, (k == 4) ? 0 : 1);
      end
      if (k == 4) check_eq("t4_err_set", a_err, 4'b1000);
      set_data(3, dv(3, k + 1));
      a_last = (k == 5) ? 4'b1000 : 4'b0000;
      @(negedge clk);
    end
    check_eq("t4_b6_data", a_tdata, dv(3, 6));
    check_eq("t4_b6_last", a_tlast, 1);
    check_eq("t4_err_hold", a_err, 4'b1000);
    a_valid = '0;
    a_clr = 1'b1;
    @(negedge clk);
    a_clr = 1'b0;
    check_eq("t4_err_clr", a_err, 4'b0000);
    check_eq("t4_idle", a_tvalid, 0);

    // Enable mask on a 3-channel instance
    b_en = 3'b101; b_valid = 3'b111; b_last = 3'b111;
    #1 check_eq("t5_ready0", b_ready, 3'b001);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq("t5_tdest", b_tdest, (k % 2 == 1) ? 2 : 0);
    end
    b_en = 3'b111; b_valid = 3'b010; b_last = 3'b000;
    #1 check_eq("t5_ready_ch1", b_ready, 3'b010);
    @(negedge clk);
    check_eq("t5_b1_dest", b_tdest, 1);
    check_eq("t5_b1_last", b_tlast, 0);
    check_eq("t5_b1_busy", b_busy, 1);
    b_en = 3'b101; b_valid = 3'b111; b_last = 3'b101;
    #1 check_eq("t5_ready_b2", b_ready, 3'b010);
    @(negedge clk);
    check_eq("t5_b2_dest", b_tdest, 1);
    b_last = 3'b111;
    #1 check_eq("t5_ready_b3", b_ready, 3'b010);
    @(negedge clk);
    check_eq("t5_b3_dest", b_tdest, 1);
    check_eq("t5_b3_last", b_tlast, 1);
    check_eq("t5_b3_busy", b_busy, 0);
    #1 check_eq("t5_ready_ch2", b_ready, 3'b100);
    @(negedge clk);
    check_eq("t5_ch2_dest", b_tdest, 2);
    b_valid = '0;

    // Asynchronous reset in the middle of a ch2 packet
    a_valid = 4'b0100; a_last = 4'b0000;
    set_data(2, dv(2, 1));
    #1 check_eq("t6_ready_ch2", a_ready, 4'b0100);
    @(negedge clk);
    set_data(2, dv(2, 2));
    check_eq("t6_busy", a_busy, 1);
    check_eq("t6_dest", a_tdest, 2);
    #2 resetn = 1'b0;
    #1;
    check_eq("t6_rst_tvalid", a_tvalid, 0);
    check_eq("t6_rst_tdata", a_tdata, 0);
    check_eq("t6_rst_tdest", a_tdest, 0);
    check_eq("t6_rst_tlast", a_tlast, 0);
    check_eq("t6_rst_ready", a_ready, 0);
    check_eq("t6_rst_busy", a_busy, 0);
    check_eq("t6_rst_grant", a_grant, 0);
    check_eq("t6_rst_b_grant", b_grant, 0);
    @(negedge clk);
    resetn = 1'b1;
    a_valid = 4'hF; a_last = 4'hF; a_en = 4'hF;
    #1 check_eq("t6_ready_first", a_ready, 4'b0001);
    @(negedge clk);
    check_eq("t6_first_dest", a_tdest, 0);
    check_eq("t6_first_valid", a_tvalid, 1);
    a_valid = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
